if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 stall_in  input  1  hazard unit hold request; freeze fetch outputs.
REQ-005 branch_taken_in  input  1  redirect request from later stage.
REQ-006 branch_target_in  input  16  redirect PC, sampled when branch_taken_in=1.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  16  read address; held stable while imem_req=1 and imem_valid=0.
REQ-009 imem_rdata  input  16  instruction word, qualified by imem_valid.
REQ-010 imem_valid  input  1  one-cycle response strobe; at most one request outstanding.
REQ-011 pc_if_out  output  16  registered PC to IF/DF buffer pc input.
REQ-012 inst_if_out  output  16  registered instruction to IF/DF buffer instruction input.
REQ-013 nop_out  output  1  registered bubble flag to IF/DF buffer nop input.
REQ-014 flush_out  output  1  one-cycle pulse to IF/DF buffer flush input.

Function
REQ-015 FSM states SHALL be RST_WAIT, FETCH, HOLD, HALT; RST_WAIT lasts exactly one cycle after reset release, then FETCH.
REQ-016 In FETCH, imem_req SHALL be 1 with imem_addr=pc, except in a cycle where a response is accepted and stall_in=1.
REQ-017 On imem_valid=1, stall_in=0, no pending discard: next edge inst_if_out<=imem_rdata, pc_if_out<=pc, nop_out<=0, pc<=pc+2; the next request issues in the following cycle.
REQ-018 PC arithmetic SHALL be modulo 2^16: 16'hFFFE+2 = 16'h0000, no error flag.
REQ-019 Any cycle without a delivered instruction SHALL register nop_out=1; pc_if_out/inst_if_out hold their last values.
REQ-020 On imem_valid=1 with stall_in=1: capture word in a one-entry hold register, go to HOLD, drop imem_req, keep pc_if_out/inst_if_out/nop_out unchanged.
REQ-021 In HOLD, the first cycle with stall_in=0 SHALL deliver the held word per REQ-017 and return to FETCH.
REQ-022 branch_taken_in=1 SHALL have priority over all other events: pc<=branch_target_in, hold register cleared, nop_out<=1, flush_out=1 (combinational, same cycle), state<=FETCH.
REQ-023 If a request is outstanding when a branch is taken, its response SHALL be discarded via a discard flag; the redirected request issues the cycle after that response arrives.
REQ-024 A branch in the same cycle as imem_valid SHALL discard that response; no discard flag is set.
REQ-025 branch_target_in bit 0 SHALL be forced to 0.

Reset
REQ-026 Asserting rst SHALL immediately: pc=RESET_VECTOR, pc_if_out=16'h0000, inst_if_out=16'h0000, nop_out=1, flush_out=0, imem_req=0, discard flag and hold register cleared, state=RST_WAIT; any outstanding memory transaction is abandoned.

Configuration
REQ-027 Macro IF_HALT_EN defined: a delivered word equal to HALT_INST SHALL move the FSM to HALT (imem_req=0, nop_out=1 from next cycle); only reset or branch_taken_in exits HALT.
REQ-028 IF_HALT_EN undefined: HALT state absent; HALT_INST is fetched and delivered like any other word.

Structure
REQ-029 Shared package SHALL hold the state enumeration, HALT_INST=16'hF000, PC_INC=16'd2 and the 16-bit word width constant.
REQ-030 The one-entry hold register with valid bit SHALL be the sub-module if_hold_reg; the FSM stays in if_fetch_unit.

Verification
REQ-031 Reset release, memory returns valid 1 cycle after each request -> pc_if_out 0000,0002,0004 on successive deliveries, nop_out=1 between them.
REQ-032 stall_in high 3 cycles as 16'h1234 returns at addr 0006 -> HOLD entered, imem_req=0; on release pc_if_out=0006, inst_if_out=1234, no word lost or duplicated.
REQ-033 branch_taken_in with target 16'h0101 while request outstanding -> flush_out pulse, stale response dropped, next imem_addr=0100.
REQ-034 RESET_VECTOR=16'hFFFC, two deliveries -> pc_if_out FFFC, FFFE, then imem_addr=0000.
REQ-035 IF_HALT_EN defined, 16'hF000 delivered -> imem_req stays 0, nop_out=1, until branch to 0040 resumes fetch at 0040.
REQ-036 rst asserted mid-HOLD -> all outputs at reset values asynchronously; fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The HALT state only exists when IF_HALT_EN is defined.
package if_fetch_unit_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t HALT_INST = 16'hF000;
  localparam word_t PC_INC    = 16'd2;

  typedef enum logic [1:0] {
    RST_WAIT,
    FETCH,
    HOLD
`ifdef IF_HALT_EN
    , HALT
`endif
  } state_t;

  // Instructions are halfword aligned, so redirect targets drop bit 0.
  function automatic word_t align_pc(input word_t addr);
    return {addr[WORD_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/if_hold_reg.sv
// One-entry skid register that parks a fetched word while the pipeline stalls.
module if_hold_reg
  import if_fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  word_t load_data,
  output word_t held_data,
  output logic  held
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_data <= '0;
      held      <= 1'b0;
    end else if (clear) begin
      held <= 1'b0;
    end else if (load) begin
      held_data <= load_data;
      held      <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: single-outstanding memory requests, stall parking,
// branch redirect with stale-response discard. Optional HALT via IF_HALT_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [15:0] branch_target_in,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] pc_if_out,
  output logic [15:0] inst_if_out,
  output logic        nop_out,
  output logic        flush_out
);

  state_t state, state_d;
  word_t  pc, pc_d;
  logic   discard, discard_d;

  logic   hold_load, hold_clear, held;
  word_t  held_data;

  logic   accept, capture, deliver, in_flight;
  word_t  deliver_word;

  if_hold_reg u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_data (imem_rdata),
    .held_data (held_data),
    .held      (held)
  );

  // A response is ours only if it was not issued before a redirect.
  assign accept       = (state == FETCH) && imem_valid && !discard;
  assign capture      = accept && stall_in && !branch_taken_in;
  assign deliver      = !branch_taken_in &&
                        ((accept && !stall_in) ||
                         ((state == HOLD) && held && !stall_in));
  assign deliver_word = (state == HOLD) ? held_data : imem_rdata;

  assign imem_req  = (state == FETCH) && !discard && !(accept && stall_in);
  assign imem_addr = pc;
  assign in_flight = (state == FETCH) && (imem_req || discard) && !imem_valid;
  assign flush_out = branch_taken_in && rst;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    discard_d  = discard;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (branch_taken_in) begin
      state_d    = FETCH;
      pc_d       = align_pc(branch_target_in);
      hold_clear = 1'b1;
      discard_d  = in_flight;
    end else begin
      case (state)
        RST_WAIT: state_d = FETCH;
        FETCH: begin
          if (discard && imem_valid) begin
            discard_d = 1'b0;
          end else if (capture) begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            hold_clear = 1'b1;
            state_d    = FETCH;
          end
        end
        default: state_d = state;
      endcase
      if (deliver) begin
        pc_d = pc + PC_INC;
`ifdef IF_HALT_EN
        if (deliver_word == HALT_INST) state_d = HALT;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RST_WAIT;
      pc      <= RESET_VECTOR;
      discard <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      discard <= discard_d;
    end
  end

  // A captured word leaves the IF/DF outputs frozen; any other
  // non-delivering cycle registers a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_if_out   <= '0;
      inst_if_out <= '0;
      nop_out     <= 1'b1;
    end else if (deliver) begin
      pc_if_out   <= pc;
      inst_if_out <= deliver_word;
      nop_out     <= 1'b0;
    end else if (!capture) begin
      nop_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: two instances (reset vectors 0000 and
// FFFC) each fed by a one-cycle-latency memory model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch;
  logic [15:0] target;
  logic        zero_bit = 1'b0;
  logic [15:0] zero_word = 16'h0000;

  logic        req_a, valid_a, nop_a, flush_a;
  logic [15:0] addr_a, rdata_a, pc_a, inst_a;
  logic        req_b, valid_b, nop_b, flush_b;
  logic [15:0] addr_b, rdata_b, pc_b, inst_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  if_fetch_unit u_dut_a (
    .clk(clk), .rst(rst), .stall_in(stall), .branch_taken_in(branch),
    .branch_target_in(target), .imem_req(req_a), .imem_addr(addr_a),
    .imem_rdata(rdata_a), .imem_valid(valid_a), .pc_if_out(pc_a),
    .inst_if_out(inst_a), .nop_out(nop_a), .flush_out(flush_a)
  );

  if_fetch_unit #(.RESET_VECTOR(16'hFFFC)) u_dut_b (
    .clk(clk), .rst(rst), .stall_in(zero_bit), .branch_taken_in(zero_bit),
    .branch_target_in(zero_word), .imem_req(req_b), .imem_addr(addr_b),
    .imem_rdata(rdata_b), .imem_valid(valid_b), .pc_if_out(pc_b),
    .inst_if_out(inst_b), .nop_out(nop_b), .flush_out(flush_b)
  );

  function automatic logic [15:0] word_at(input logic [15:0] a);
    case (a)
      16'h0006: return 16'h1234;
      16'h0102: return 16'hF000;
      default:  return a ^ 16'h5A00;
    endcase
  endfunction

  // Memory answers one cycle after a request is presented.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      valid_a <= req_a && !valid_a;
      valid_b <= req_b && !valid_b;
      rdata_a <= word_at(addr_a);
      rdata_b <= word_at(addr_b);
    end
  end

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid_a && n < 10) begin
      tick();
      n++;
    end
    check("wait_valid", {15'd0, valid_a}, 16'h0001);
  endtask

  initial begin
    logic [15:0] prev_pc;
    rst = 1'b0; stall = 1'b0; branch = 1'b0; target = '0;
    repeat (2) tick();
    check("rst_pc",    pc_a,    16'h0000);
    check("rst_inst",  inst_a,  16'h0000);
    check("rst_nop",   nop_a,   16'h0001);
    check("rst_req",   req_a,   16'h0000);
    check("rst_flush", flush_a, 16'h0000);

    rst = 1'b1; #1;
    check("rst_wait_req", req_a, 16'h0000);
    tick();
    check("c1_req",  req_a,  16'h0001);
    check("c1_addr", addr_a, 16'h0000);
    check("b_addr0", addr_b, 16'hFFFC);
    tick(); tick();
    check("d0_pc",   pc_a,   16'h0000);
    check("d0_inst", inst_a, 16'h5A00);
    check("d0_nop",  nop_a,  16'h0000);
    check("b_d0_pc", pc_b,   16'hFFFC);
    check("c3_addr", addr_a, 16'h0002);
    tick();
    check("gap_nop", nop_a,  16'h0001);
    check("gap_pc",  pc_a,   16'h0000);
    tick();
    check("d1_pc",   pc_a,   16'h0002);
    check("d1_nop",  nop_a,  16'h0000);
    check("b_d1_pc", pc_b,   16'hFFFE);
    check("b_wrap",  addr_b, 16'h0000);
    tick(); tick();
    check("d2_pc",   pc_a,   16'h0004);

    // Stall as 1234 returns from 0006.
    tick();
    stall = 1'b1; #1;
    check("cap_req", req_a, 16'h0000);
    tick();
    check("hold_req", req_a, 16'h0000);
    check("hold_pc",  pc_a,  16'h0004);
    check("hold_nop", nop_a, 16'h0001);
    tick();
    stall = 1'b0;
    tick();
    check("rel_pc",   pc_a,   16'h0006);
    check("rel_inst", inst_a, 16'h1234);
    check("rel_nop",  nop_a,  16'h0000);
    check("rel_addr", addr_a, 16'h0008);
    tick(); tick();
    check("d4_pc",   pc_a,   16'h0008);
    check("d4_inst", inst_a, 16'h5A08);

    // Branch while the 000A request is outstanding.
    branch = 1'b1; target = 16'h0101; #1;
    check("br_flush", flush_a, 16'h0001);
    tick();
    branch = 1'b0; #1;
    check("br_flush_end", flush_a, 16'h0000);
    check("discard_req",  req_a,   16'h0000);
    tick();
    check("discard_nop",  nop_a,   16'h0001);
    check("discard_pc",   pc_a,    16'h0008);
    check("redir_req",    req_a,   16'h0001);
    check("redir_addr",   addr_a,  16'h0100);
    tick(); tick();
    check("d100_pc",   pc_a,   16'h0100);
    check("d100_inst", inst_a, 16'h5B00);
    tick(); tick();
    check("halt_pc",   pc_a,   16'h0102);
    check("halt_inst", inst_a, 16'hF000);
    check("halt_nop",  nop_a,  16'h0000);
`ifdef IF_HALT_EN
    check("halted_req", req_a, 16'h0000);
    repeat (3) tick();
    check("halted_req2", req_a, 16'h0000);
    check("halted_nop",  nop_a, 16'h0001);
    branch = 1'b1; target = 16'h0040; #1;
    check("unhalt_flush", flush_a, 16'h0001);
    tick();
    branch = 1'b0; #1;
    check("unhalt_req",  req_a,  16'h0001);
    check("unhalt_addr", addr_a, 16'h0040);
    prev_pc = 16'h0102;
`else
    check("nohalt_req",  req_a,  16'h0001);
    check("nohalt_addr", addr_a, 16'h0104);
    tick(); tick();
    check("d104_pc", pc_a, 16'h0104);
    prev_pc = 16'h0104;
`endif

    // Branch coinciding with a response: no discard, immediate redirect.
    wait_valid();
    branch = 1'b1; target = 16'h0201; #1;
    check("brv_flush", flush_a, 16'h0001);
    tick();
    branch = 1'b0; #1;
    check("brv_req",  req_a,  16'h0001);
    check("brv_addr", addr_a, 16'h0200);
    check("brv_nop",  nop_a,  16'h0001);
    check("brv_pc",   pc_a,   prev_pc);

    // Reset while parked in HOLD.
    tick();
    stall = 1'b1; #1;
    check("cap2_req", req_a, 16'h0000);
    tick();
    rst = 1'b0; branch = 1'b1; #1;
    check("arst_pc",    pc_a,    16'h0000);
    check("arst_inst",  inst_a,  16'h0000);
    check("arst_nop",   nop_a,   16'h0001);
    check("arst_req",   req_a,   16'h0000);
    check("arst_flush", flush_a, 16'h0000);
    branch = 1'b0; stall = 1'b0;
    tick();
    rst = 1'b1; #1;
    check("rst2_req", req_a, 16'h0000);
    tick();
    check("rst2_req1",  req_a,  16'h0001);
    check("rst2_addr",  addr_a, 16'h0000);
    tick(); tick();
    check("rst2_pc",   pc_a,   16'h0000);
    check("rst2_inst", inst_a, 16'h5A00);
    check("rst2_nop",  nop_a,  16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
